ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes decoded operands and funct3 from ID/EX and produces a 32-bit result for the EX/MEM register.
- Multiplies take 2 cycles; divides use an iterative radix-2 divider.
- Holds the front of the pipeline via stall_o until the result is ready.

Parameters:
- XLEN, 32, operand/result width.
- DIV_ITERS, XLEN, divider iterations; always equals XLEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_e  in  1  M-extension op present in ID/EX this cycle.
- op_e  in  3  funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- rs1_e  in  XLEN  operand A (RD1 after forwarding).
- rs2_e  in  XLEN  operand B (RD2 after forwarding).
- rd_e  in  5  destination register.
- flush_e  in  1  squash the op in EX (branch/jump redirect).
- stall_o  out  1  freeze PC, IF/ID and ID/EX.
- result_valid_o  out  1  one-cycle pulse; result_o/rd_o valid.
- result_o  out  XLEN  product or quotient/remainder.
- rd_o  out  5  captured rd_e.

Behaviour:
- Reset is asynchronous and active-high.
  - Forces state IDLE.
  - result_o=0, rd_o=0, result_valid_o=0, stall_o=0, all internal registers 0.
  - Takes effect mid-operation with no clock edge; the op is lost.
- States: IDLE, MUL, DIV, DONE.
- Cycle numbering: cycle 0 is the cycle valid_e=1 in IDLE with flush_e=0. At the end of cycle 0 the unit captures op, operands and rd.
- IDLE transitions at end of cycle 0:
  - MUL-class op -> MUL.
  - DIV/REM with rs2=0 -> DONE (fast path).
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, signed ops only -> DONE (fast path).
  - Any other DIV/REM -> DIV, iteration counter cleared.
- MUL (1 cycle):
  - Computes the 66-bit product of 33-bit sign- or zero-extended operands, per op.
  - Registers the low 32 bits (MUL) or bits 63:32 (MULH*).
  - Transitions to DONE.
- DIV (DIV_ITERS cycles):
  - Restoring division on absolute values for signed ops; one quotient bit per cycle, MSB first.
  - After iteration DIV_ITERS, applies signs and transitions to DONE.
  - Quotient is negated if operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE (1 cycle):
  - result_valid_o=1, stall_o=0.
  - valid_e is ignored because ID/EX still shows the same op this cycle.
  - Next state is IDLE.
- Latency: result_valid_o asserts in cycle 2 for MUL, cycle 33 for DIV, cycle 1 for fast paths.
- stall_o (combinational):
  - 1 when (IDLE & valid_e & ~flush_e) or state is MUL or DIV.
  - 0 otherwise.
  - Stall counts: MUL 2 cycles, DIV 33 cycles, fast path 1 cycle.
- Fast-path results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1.
  - Signed overflow: quotient=0x80000000, remainder=0.
- flush_e:
  - In IDLE: op not accepted, stall_o=0 in that same cycle.
  - In MUL or DIV: stall_o=0 in that same cycle, next state IDLE, no result_valid_o.
  - In DONE: flush_e is ignored; the result completes.
- rd_e=0: the op executes normally and rd_o=0; writeback discards it.
- result_o and rd_o hold their last value outside DONE. Consumers qualify them with result_valid_o.

Decomposition:
- Pkg additions:
  - muldiv_op_t enum (3-bit funct3 encodings above).
  - muldiv_state_t enum (IDLE, MUL, DIV, DONE).
  - Constants DIV_BY_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module div_core (iterative unsigned restoring divider):
  - Inputs: clk, reset, start, dividend, divisor.
  - Outputs: busy, done, quotient, remainder.
  - Also accepts an abort input driven by flush_e.
- The top level handles decode, sign fix-up, the multiplier, the FSM and the stall logic.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> stall_o=1 in cycles 0-1; cycle 2 result_valid_o=1, result_o=0xFFFFFFEB, rd_o=rd_e.
- rs1=rs2=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF, MUL=0x00000001.
- DIV 0xFFFFFFF9 / 2 -> cycle 33 result_o=0xFFFFFFFD with stall_o high exactly 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7=14, REMU=2.
- Fast paths, each with result_valid_o in cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush: DIV issued, flush_e=1 in cycle 10 -> stall_o=0 in cycle 10, no result_valid_o. MUL issued in cycle 12 -> result_valid_o in cycle 14, correct value.
- Async reset mid-DIV (cycle 15, between edges) -> stall_o, result_valid_o, result_o go 0 immediately. After release, a MUL completes normally.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the RV32M execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// quotient/remainder are the post-step values and are final in the cycle done is high.
module ex_muldiv_div_core #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic            w_last;

  // The true difference always fits in XLEN bits when w_ge holds.
  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift[XLEN-1:0] - r_dvs;
    w_last  = r_busy && (r_cnt == CW'(DIV_ITERS - 1));
  end

  assign busy      = r_busy;
  assign done      = w_last;
  assign quotient  = {r_quo[XLEN-2:0], w_ge};
  assign remainder = w_ge ? w_diff : w_shift[XLEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_quo  <= dividend;
      r_rem  <= '0;
      r_dvs  <= divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo <= quotient;
      r_rem <= remainder;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the execute stage: decode, 2-cycle multiply,
// iterative divide with sign fix-up and fast paths, FSM and pipeline stall.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic [2:0]      op_e,
  input  logic [XLEN-1:0] rs1_e,
  input  logic [XLEN-1:0] rs2_e,
  input  logic [4:0]      rd_e,
  input  logic            flush_e,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  muldiv_state_t r_state, w_next_state;
  muldiv_op_t    r_op;
  logic [XLEN-1:0] r_a, r_b, r_result;
  logic [4:0]      r_rd, r_rd_out;

  logic            w_accept, w_div_op, w_div0, w_ovf, w_fast, w_div_start;
  logic            w_div_busy, w_div_done, w_div_sgn, w_a_sgn, w_b_sgn;
  logic [XLEN-1:0] w_fast_res, w_abs_a, w_abs_b, w_quo, w_rem, w_div_res, w_mul_res;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_accept    = (r_state == S_IDLE) && valid_e && !flush_e;
    w_div_op    = op_e[2];
    w_div0      = (rs2_e == '0);
    w_ovf       = !op_e[0] && (rs1_e == INT_MIN) && (rs2_e == '1);
    w_fast      = w_div_op && (w_div0 || w_ovf);
    w_div_start = w_accept && w_div_op && !w_fast;
    w_abs_a     = (!op_e[0] && rs1_e[XLEN-1]) ? -rs1_e : rs1_e;
    w_abs_b     = (!op_e[0] && rs2_e[XLEN-1]) ? -rs2_e : rs2_e;
    if (w_div0) w_fast_res = op_e[1] ? rs1_e : DIV_BY_ZERO_Q;
    else        w_fast_res = op_e[1] ? '0 : INT_MIN;
  end

  // Low 64 bits of the 66-bit product of the 33-bit extended operands.
  always_comb begin
    w_a_sgn   = (r_op == OP_MULH || r_op == OP_MULHSU) && r_a[XLEN-1];
    w_b_sgn   = (r_op == OP_MULH) && r_b[XLEN-1];
    w_prod    = {{XLEN{w_a_sgn}}, r_a} * {{XLEN{w_b_sgn}}, r_b};
    w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_div_sgn = (r_op == OP_DIV) || (r_op == OP_REM);
    if (r_op == OP_REM || r_op == OP_REMU)
      w_div_res = (w_div_sgn && r_a[XLEN-1]) ? -w_rem : w_rem;
    else
      w_div_res = (w_div_sgn && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_quo : w_quo;
  end

  ex_muldiv_div_core #(
    .XLEN      (XLEN),
    .DIV_ITERS (DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .start     (w_div_start),
    .abort     (flush_e),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = !w_div_op ? S_MUL : (w_fast ? S_DONE : S_DIV);
      S_MUL:  w_next_state = flush_e ? S_IDLE : S_DONE;
      S_DIV: begin
        if (flush_e || !w_div_busy) w_next_state = S_IDLE;
        else if (w_div_done)        w_next_state = S_DONE;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    stall_o        = !reset && (w_accept || ((r_state == S_MUL || r_state == S_DIV) && !flush_e));
    result_valid_o = (r_state == S_DONE);
  end

  // result/rd outputs only change on the edge into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op <= muldiv_op_t'(op_e);
        r_a  <= rs1_e;
        r_b  <= rs2_e;
        r_rd <= rd_e;
        if (w_fast) begin
          r_result <= w_fast_res;
          r_rd_out <= rd_e;
        end
      end
      if (r_state == S_MUL && !flush_e) begin
        r_result <= w_mul_res;
        r_rd_out <= r_rd;
      end
      if (r_state == S_DIV && !flush_e && w_div_done) begin
        r_result <= w_div_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign result_o = r_result;
  assign rd_o     = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized bench for ex_muldiv: a cycle-level arithmetic model sets the
// expected outputs each cycle and one negedge process compares them.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_e = 1'b0;
  logic [2:0]  op_e = '0;
  logic [31:0] rs1_e = '0;
  logic [31:0] rs2_e = '0;
  logic [4:0]  rd_e = '0;
  logic        flush_e = 1'b0;
  logic        stall_o, result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_vld;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  ex_muldiv dut (
    .clk            (clk),
    .reset          (reset),
    .valid_e        (valid_e),
    .op_e           (op_e),
    .rs1_e          (rs1_e),
    .rs2_e          (rs2_e),
    .rd_e           (rd_e),
    .flush_e        (flush_e),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_o           (rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Architectural results computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * longint'({32'b0, b});
      3'd3:       p = {32'b0, a} * {32'b0, b};
      default:    p = '0;
    endcase
    case (op)
      3'd0:             return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:             return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5:             return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:             return (b == 0) ? a : 32'(sa % sb);
      default:          return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      chk("result_valid_o", 32'(result_valid_o), 32'(exp_vld));
      chk("result_o", result_o, exp_res);
      chk("rd_o", 32'(rd_o), 32'(exp_rd));
    end
  end

  task automatic drive_cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic fl,
                             input logic e_stall, input logic e_vld);
    valid_e = v; op_e = op; rs1_e = a; rs2_e = b; rd_e = rd; flush_e = fl;
    exp_stall = e_stall; exp_vld = e_vld; exp_res = last_res; exp_rd = last_rd;
    chk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // valid_e is held through DONE, as ID/EX would be while stalled.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int flush_at);
    int L;
    logic fl, dn;
    L = latency(op, a, b);
    for (int k = 0; k <= L; k++) begin
      fl = (k == flush_at);
      dn = (k == L);
      if (dn) begin
        last_res = exp;
        last_rd  = rd;
      end
      drive_cycle(1'b1, op, a, b, rd, fl, !dn && !fl, dn);
      if (fl) break;
    end
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic directed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    chk("model_pin", ref_result(op, a, b), exp);
    run_op(op, a, b, 5'(op + 3'd1), exp, -1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          fa;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_valid", 32'(result_valid_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_rd", 32'(rd_o), 32'd0);
    reset = 1'b0;

    directed(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
    directed(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed(OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001);
    directed(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    directed(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    directed(OP_DIVU,   32'd100,        32'd7,         32'd14);
    directed(OP_REMU,   32'd100,        32'd7,         32'd2);
    directed(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
    directed(OP_REMU,   32'd5,          32'd0,         32'd5);
    directed(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    directed(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    directed(OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);

    // Flushed divide, then a multiply issued two cycles later.
    run_op(OP_DIV, 32'd1000, 32'd3, 5'd4, 32'd333, 10);
    run_op(OP_MUL, 32'd6, 32'd9, 5'd0, 32'd54, -1);
    run_op(OP_MUL, 32'd2, 32'd3, 5'd7, 32'd6, 0);
    run_op(OP_MULHU, 32'd2, 32'd3, 5'd7, 32'd0, 1);
    run_op(OP_DIVU, 32'd9, 32'd2, 5'd3, 32'd4, 33);

    // Asynchronous reset between edges in cycle 15 of a divide.
    for (int k = 0; k < 15; k++)
      drive_cycle(1'b1, OP_DIV, 32'd1000, 32'd3, 5'd9, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_stall", 32'(stall_o), 32'd0);
    chk("async_rst_valid", 32'(result_valid_o), 32'd0);
    chk("async_rst_result", result_o, 32'd0);
    chk("async_rst_rd", 32'(rd_o), 32'd0);
    last_res = '0;
    last_rd  = '0;
    @(posedge clk); #1 valid_e = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_op(OP_MUL, 32'd11, 32'd13, 5'd21, 32'd143, -1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, latency(op, a, b)) : -1;
      run_op(op, a, b, 5'($urandom_range(0, 31)), ref_result(op, a, b), fa);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
